// File: rtl/iwram_bus_ctrl_pkg.sv
// Shared IWRAM bus types: access-size encoding, controller FSM states, region constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package gba_mem_pkg;

    localparam int         IWRAM_AW = 14;
    localparam logic [7:0] REGION   = 8'h03;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } state_e;

    // A request is rejected when it falls outside the IWRAM region or uses the reserved size code.
    function automatic logic req_err(input logic [7:0] region, input logic [1:0] size);
        return (region != REGION) || (size == 2'd3);
    endfunction

endpackage

// File: rtl/iwram_bus_ctrl_if.sv
// CPU-side request/response bundle for the IWRAM controller.
// Latency: none (wires only).
// Backpressure: master holds request fields stable until bus_ack.
interface iwram_bus_if;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_addr, bus_we, bus_size, bus_wdata,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_addr, bus_we, bus_size, bus_wdata,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/iwram_lane_merge.sv
// Byte/halfword lane insert for read-modify-write and lane extract with zero-extension for reads.
// Latency: combinational.
// Backpressure: none.
module iwram_lane_merge
    import gba_mem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    // Word accesses pass straight through; sub-word accesses touch only the addressed lane.
    always_comb begin
        merged    = word;
        extracted = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0: begin merged[7:0]   = wdata[7:0]; extracted = {24'h0, word[7:0]};   end
                    2'd1: begin merged[15:8]  = wdata[7:0]; extracted = {24'h0, word[15:8]};  end
                    2'd2: begin merged[23:16] = wdata[7:0]; extracted = {24'h0, word[23:16]}; end
                    default: begin merged[31:24] = wdata[7:0]; extracted = {24'h0, word[31:24]}; end
                endcase
            end
            SZ_HALF: begin
                // lane[0] is ignored for halfwords
                if (lane[1]) begin
                    merged[31:16] = wdata[15:0];
                    extracted     = {16'h0, word[31:16]};
                end else begin
                    merged[15:0]  = wdata[15:0];
                    extracted     = {16'h0, word[15:0]};
                end
            end
            default: begin
                merged    = wdata;
                extracted = word;
            end
        endcase
    end

endmodule

// File: rtl/iwram_bus_ctrl.sv
// CPU bus to IWRAM port A controller: region decode with mirroring, sub-word stores via read-modify-write.
// Latency: ack 1 cycle after accept on error, 2 for read/word write, 3 for byte/halfword write.
// Backpressure: one request in flight; bus_req is ignored until the FSM returns to IDLE after the ack.
module iwram_bus_ctrl
    import gba_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    iwram_bus_if.slave          bus,
    output logic [IWRAM_AW-1:0] ram_addr,
    output logic                ram_we,
    output logic [31:0]         ram_din,
    input  logic [31:0]         ram_dout
);

    state_e      state;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic        req_bad;
    logic        unused_addr;

    // Mirror bits above the RAM word address are deliberately dropped.
    assign unused_addr = ^bus.bus_addr[23:IWRAM_AW+2];

    assign req_bad = req_err(bus.bus_addr[31:24], bus.bus_size);

    // Port A is only written in the two store states, so an async reset kills a pending write.
    assign ram_we = (state == WRITE) || (state == RMW_WR);

    assign bus.bus_ack   = ack_q;
    assign bus.bus_err   = err_q;
    assign bus.bus_rdata = rdata_q;

    iwram_lane_merge u_lane_merge (
        .size      (size_e'(size_q)),
        .lane      (lane_q),
        .word      (ram_dout),
        .wdata     (wdata_q),
        .merged    (merged),
        .extracted (extracted)
    );

    // Request sequencing: accept in IDLE, one RAM access phase per state, single-cycle ack in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lane_q   <= 2'd0;
            size_q   <= 2'd0;
            wdata_q  <= 32'h0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            ram_addr <= '0;
            ram_din  <= 32'h0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.bus_req) begin
                        ram_addr <= bus.bus_addr[IWRAM_AW+1:2];
                        lane_q   <= bus.bus_addr[1:0];
                        size_q   <= bus.bus_size;
                        wdata_q  <= bus.bus_wdata;
                        if (req_bad) begin
                            state <= DONE;
                            ack_q <= 1'b1;
                            err_q <= 1'b1;
                        end else if (!bus.bus_we) begin
                            state <= READ;
                        end else if (bus.bus_size == SZ_WORD) begin
                            state   <= WRITE;
                            ram_din <= bus.bus_wdata;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                READ: begin
                    rdata_q <= extracted;
                    state   <= DONE;
                    ack_q   <= 1'b1;
                end
                WRITE: begin
                    state <= DONE;
                    ack_q <= 1'b1;
                end
                RMW_RD: begin
                    // Old word with the new lane spliced in becomes the store data.
                    ram_din <= merged;
                    state   <= RMW_WR;
                end
                RMW_WR: begin
                    state <= DONE;
                    ack_q <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iwram_bus_ctrl.sv
// Directed self-checking bench for iwram_bus_ctrl with a behavioural 16K x 32 RAM on port A.
// Latency: n/a.
// Backpressure: n/a.
module tb_iwram_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [31:0] mem [0:16383];
    int          errors;
    int          checks;
    int          cyc;

    iwram_bus_if bus ();

    iwram_bus_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM port A: combinational read, word write on the clock edge.
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    // Issue one request in the next cycle (cycle 0) and follow it until ack or an 8-cycle budget.
    task automatic do_xfer(input logic [31:0] a, input logic w, input logic [1:0] s,
                           input logic [31:0] d, output int ack_cyc, output logic [31:0] rd,
                           output logic er, output logic [7:0] we_mask,
                           output logic [13:0] addr1, output int t0);
        @(posedge clk); #1;
        bus.bus_req   = 1'b1;
        bus.bus_addr  = a;
        bus.bus_we    = w;
        bus.bus_size  = s;
        bus.bus_wdata = d;
        t0      = cyc;
        ack_cyc = -1;
        rd      = 32'h0;
        er      = 1'b0;
        we_mask = 8'h0;
        addr1   = 14'h0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 1) addr1 = ram_addr;
            if (ram_we) we_mask[k] = 1'b1;
            if (bus.bus_ack) begin
                ack_cyc = k;
                rd      = bus.bus_rdata;
                er      = bus.bus_err;
                break;
            end
        end
        bus.bus_req = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.bus_ack !== 1'b0)    begin errors++; $display("FAIL reset_ack: got %b want 0", bus.bus_ack); end
        checks++; if (bus.bus_err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", bus.bus_err); end
        checks++; if (bus.bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.bus_rdata); end
        checks++; if (ram_we !== 1'b0)         begin errors++; $display("FAIL reset_we: got %b want 0", ram_we); end
        checks++; if (ram_addr !== 14'h0)      begin errors++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
        checks++; if (ram_din !== 32'h0)       begin errors++; $display("FAIL reset_din: got %h want 0", ram_din); end
    endtask

    task automatic test_word_write();
        int ac; int t0; logic [31:0] rd; logic er; logic [7:0] wm; logic [13:0] a1;
        do_xfer(32'h0300_0010, 1'b1, 2'd2, 32'hDEAD_BEEF, ac, rd, er, wm, a1, t0);
        checks++; if (a1 !== 14'h0004)         begin errors++; $display("FAIL ww_addr: got %h want 0004", a1); end
        checks++; if (wm !== 8'b0000_0010)     begin errors++; $display("FAIL ww_we_cycles: got %b want 00000010", wm); end
        checks++; if (ac !== 2)                begin errors++; $display("FAIL ww_ack_cycle: got %0d want 2", ac); end
        checks++; if (er !== 1'b0)             begin errors++; $display("FAIL ww_err: got %b want 0", er); end
        checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ww_ram: got %h want deadbeef", mem[4]); end
        // Highest word in the region
        do_xfer(32'h0300_FFFC, 1'b1, 2'd2, 32'hCAFE_F00D, ac, rd, er, wm, a1, t0);
        checks++; if (a1 !== 14'h3FFF)          begin errors++; $display("FAIL ww_top_addr: got %h want 3fff", a1); end
        checks++; if (mem[16383] !== 32'hCAFE_F00D) begin errors++; $display("FAIL ww_top_ram: got %h want cafef00d", mem[16383]); end
    endtask

    task automatic test_subword_write();
        int ac; int t0; logic [31:0] rd; logic er; logic [7:0] wm; logic [13:0] a1;
        mem[4] = 32'h1122_3344;
        do_xfer(32'h0300_0013, 1'b1, 2'd0, 32'h0000_00AA, ac, rd, er, wm, a1, t0);
        checks++; if (mem[4] !== 32'hAA22_3344) begin errors++; $display("FAIL bw_ram: got %h want aa223344", mem[4]); end
        checks++; if (ac !== 3)                 begin errors++; $display("FAIL bw_ack_cycle: got %0d want 3", ac); end
        checks++; if (wm !== 8'b0000_0100)      begin errors++; $display("FAIL bw_we_cycles: got %b want 00000100", wm); end
        checks++; if (er !== 1'b0)              begin errors++; $display("FAIL bw_err: got %b want 0", er); end
        // Halfword store uses only wdata[15:0]
        mem[5] = 32'h0000_0000;
        do_xfer(32'h0300_0016, 1'b1, 2'd1, 32'h1234_BEEF, ac, rd, er, wm, a1, t0);
        checks++; if (mem[5] !== 32'hBEEF_0000) begin errors++; $display("FAIL hw_ram: got %h want beef0000", mem[5]); end
        checks++; if (ac !== 3)                 begin errors++; $display("FAIL hw_ack_cycle: got %0d want 3", ac); end
    endtask

    task automatic test_reads();
        int ac; int t0; logic [31:0] rd; logic er; logic [7:0] wm; logic [13:0] a1;
        do_xfer(32'h0300_0012, 1'b0, 2'd1, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (rd !== 32'h0000_AA22) begin errors++; $display("FAIL rd_half: got %h want 0000aa22", rd); end
        checks++; if (ac !== 2)             begin errors++; $display("FAIL rd_half_ack: got %0d want 2", ac); end
        checks++; if (wm !== 8'h00)         begin errors++; $display("FAIL rd_half_we: got %b want 0", wm); end
        do_xfer(32'h0300_0010, 1'b0, 2'd0, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (rd !== 32'h0000_0044) begin errors++; $display("FAIL rd_byte0: got %h want 00000044", rd); end
        do_xfer(32'h0300_0017, 1'b0, 2'd0, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (rd !== 32'h0000_00BE) begin errors++; $display("FAIL rd_byte3: got %h want 000000be", rd); end
        do_xfer(32'h0300_0013, 1'b0, 2'd2, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (rd !== 32'hAA22_3344) begin errors++; $display("FAIL rd_word_unaligned: got %h want aa223344", rd); end
    endtask

    task automatic test_mirror();
        int ac; int t0; logic [31:0] rd; logic er; logic [7:0] wm; logic [13:0] a1;
        do_xfer(32'h0301_0010, 1'b0, 2'd2, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (a1 !== 14'h0004)      begin errors++; $display("FAIL mir_addr: got %h want 0004", a1); end
        checks++; if (rd !== 32'hAA22_3344) begin errors++; $display("FAIL mir_data: got %h want aa223344", rd); end
        do_xfer(32'h03FF_0010, 1'b0, 2'd2, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (a1 !== 14'h0004)      begin errors++; $display("FAIL mir_hi_addr: got %h want 0004", a1); end
    endtask

    task automatic test_errors();
        int ac; int t0; logic [31:0] rd; logic er; logic [7:0] wm; logic [13:0] a1;
        mem[0] = 32'h5A5A_5A5A;
        do_xfer(32'h0200_0000, 1'b1, 2'd2, 32'h1111_1111, ac, rd, er, wm, a1, t0);
        checks++; if (ac !== 1)     begin errors++; $display("FAIL err_region_ack: got %0d want 1", ac); end
        checks++; if (er !== 1'b1)  begin errors++; $display("FAIL err_region_err: got %b want 1", er); end
        checks++; if (wm !== 8'h00) begin errors++; $display("FAIL err_region_we: got %b want 0", wm); end
        do_xfer(32'h0300_0000, 1'b1, 2'd3, 32'h2222_2222, ac, rd, er, wm, a1, t0);
        checks++; if (ac !== 1)     begin errors++; $display("FAIL err_size_ack: got %0d want 1", ac); end
        checks++; if (er !== 1'b1)  begin errors++; $display("FAIL err_size_err: got %b want 1", er); end
        checks++; if (wm !== 8'h00) begin errors++; $display("FAIL err_size_we: got %b want 0", wm); end
        checks++; if (mem[0] !== 32'h5A5A_5A5A) begin errors++; $display("FAIL err_ram: got %h want 5a5a5a5a", mem[0]); end
    endtask

    task automatic test_back_to_back();
        int ac; int t_first; int t0; logic [31:0] rd; logic er; logic [7:0] wm; logic [13:0] a1;
        do_xfer(32'h0300_0010, 1'b0, 2'd2, 32'h0, ac, rd, er, wm, a1, t_first);
        do_xfer(32'h0300_0014, 1'b0, 2'd2, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (rd !== 32'hBEEF_0000) begin errors++; $display("FAIL b2b_data: got %h want beef0000", rd); end
        do_xfer(32'h0300_0010, 1'b0, 2'd0, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if ((t0 + ac - t_first) !== 8) begin errors++; $display("FAIL b2b_span: got %0d want 8", t0 + ac - t_first); end
        @(posedge clk); #1;
        checks++; if (bus.bus_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_pulse: got %b want 0", bus.bus_ack); end
    endtask

    task automatic test_reset_mid();
        int ac; int t0; logic [31:0] rd; logic er; logic [7:0] wm; logic [13:0] a1;
        logic seen_ack;
        // Reset while in RMW_RD
        @(posedge clk); #1;
        bus.bus_req = 1'b1; bus.bus_addr = 32'h0300_0011; bus.bus_we = 1'b1;
        bus.bus_size = 2'd0; bus.bus_wdata = 32'h55;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        bus.bus_req = 1'b0;
        checks++; if ({bus.bus_ack, bus.bus_err, bus.bus_rdata, ram_we, ram_addr, ram_din} !== 80'h0) begin
            errors++; $display("FAIL rst_rmwrd_outputs: got ack=%b err=%b rdata=%h we=%b addr=%h din=%h want all 0",
                               bus.bus_ack, bus.bus_err, bus.bus_rdata, ram_we, ram_addr, ram_din);
        end
        seen_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus.bus_ack) seen_ack = 1'b1; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (bus.bus_ack) seen_ack = 1'b1; end
        checks++; if (seen_ack !== 1'b0)       begin errors++; $display("FAIL rst_rmwrd_noack: got %b want 0", seen_ack); end
        checks++; if (mem[4] !== 32'hAA22_3344) begin errors++; $display("FAIL rst_rmwrd_ram: got %h want aa223344", mem[4]); end
        // Reset while in RMW_WR, before the write edge
        @(posedge clk); #1;
        bus.bus_req = 1'b1; bus.bus_addr = 32'h0300_0012; bus.bus_we = 1'b1;
        bus.bus_size = 2'd1; bus.bus_wdata = 32'h9999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.bus_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (mem[4] !== 32'hAA22_3344) begin errors++; $display("FAIL rst_rmwwr_ram: got %h want aa223344", mem[4]); end
        checks++; if (bus.bus_ack !== 1'b0)     begin errors++; $display("FAIL rst_rmwwr_ack: got %b want 0", bus.bus_ack); end
        rst_n = 1'b1;
        do_xfer(32'h0300_0010, 1'b0, 2'd2, 32'h0, ac, rd, er, wm, a1, t0);
        checks++; if (rd !== 32'hAA22_3344) begin errors++; $display("FAIL rst_after_read: got %h want aa223344", rd); end
        checks++; if (ac !== 2)             begin errors++; $display("FAIL rst_after_ack: got %0d want 2", ac); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        rst_n         = 1'b0;
        bus.bus_req   = 1'b0;
        bus.bus_addr  = 32'h0;
        bus.bus_we    = 1'b0;
        bus.bus_size  = 2'd0;
        bus.bus_wdata = 32'h0;
        #2;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_word_write();
        test_subword_write();
        test_reads();
        test_mirror();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
